// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one embedded RAM port between the instruction-fetch requester
// (F phase) and the data requester (M phase: load/store/push/pop). Every
// access is serialised through a four-state FSM (IDLE, WR, RD, DONE). The
// block drives the RAM control pins and returns read data through per-port
// req/ack handshakes. busy lets the phase sequencer stall while an access is
// in flight.
//
// Optional build macro:
//   ARB_RR_EN  defined   -> round-robin arbitration between fetch and data
//              undefined -> fixed priority; data beats fetch
//
// Parameters:
//   AW      RAM address width
//   DW      RAM data width
//   RD_LAT  RAM read latency in cycles (1..4). It is counted from the edge
//           that captures ram_ra to the cycle in which ram_q is valid.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   if_req/if_addr      fetch request (held until if_ack) and fetch address
//   if_ack/if_rdata     one-cycle fetch-complete pulse and fetched word
//   d_req/d_we          data request (held until d_ack); 1 = write, 0 = read
//   d_addr/d_wdata      data address and store data
//   d_ack/d_rdata       one-cycle data-complete pulse and load data
//   ram_ra/ram_wa       RAM read and write addresses
//   ram_data/ram_wren   RAM write data and write enable
//   ram_q               RAM registered read data
//   busy                high whenever the FSM is not in IDLE
//
// All outputs are registered. While rst_n is low, every output is 0.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] ram_ra,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  // The RD state lasts RD_LAT+1 cycles. rd_cnt runs from 0 up to RD_LAST,
  // and the cycle in which it equals RD_LAST is the final RD cycle.
  localparam logic [2:0] RD_LAST = 3'(RD_LAT);

  state_t        state, state_nxt;
  logic [2:0]    rd_cnt, rd_cnt_nxt;
  logic          win_d, win_d_nxt;
  logic [AW-1:0] lat_addr, lat_addr_nxt;

  logic          if_ack_nxt, d_ack_nxt, ram_wren_nxt, busy_nxt;
  logic [AW-1:0] ram_ra_nxt, ram_wa_nxt;
  logic [DW-1:0] ram_data_nxt;
  logic          cap_if, cap_d;

  logic          grant_if, grant_d;

`ifdef ARB_RR_EN
  // Round-robin: last_winner is 0 after a fetch grant and 1 after a data
  // grant. On a tie, the port that did not win last time gets the grant.
  // A lone request always wins.
  logic last_winner;

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (if_req && d_req) begin
      grant_d  = ~last_winner;
      grant_if = last_winner;
    end else begin
      grant_d  = d_req;
      grant_if = if_req;
    end
  end

  // Record the winner of every grant. A grant can only happen in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner <= 1'b0;
    end else if (state == IDLE && (grant_if || grant_d)) begin
      last_winner <= grant_d;
    end
  end
`else
  // Fixed priority: data wins, so the M phase completes before the next
  // F phase. Fetch can starve while d_req stays high.
  assign grant_d  = d_req;
  assign grant_if = if_req & ~d_req;
`endif

  // State register, together with the transaction context latched in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      win_d    <= 1'b0;
      lat_addr <= '0;
    end else begin
      state    <= state_nxt;
      rd_cnt   <= rd_cnt_nxt;
      win_d    <= win_d_nxt;
      lat_addr <= lat_addr_nxt;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // and registered, so each pin changes on the edge that enters its state.
  // The write address and data go straight into the ram_wa/ram_data
  // registers on the grant edge. Those registers act as the write latch for
  // the single WR cycle.
  always_comb begin
    state_nxt    = state;
    rd_cnt_nxt   = rd_cnt;
    win_d_nxt    = win_d;
    lat_addr_nxt = lat_addr;
    if_ack_nxt   = 1'b0;
    d_ack_nxt    = 1'b0;
    ram_wren_nxt = 1'b0;
    ram_ra_nxt   = '0;
    ram_wa_nxt   = '0;
    ram_data_nxt = '0;
    cap_if       = 1'b0;
    cap_d        = 1'b0;

    unique case (state)
      IDLE: begin
        if (grant_d || grant_if) begin
          win_d_nxt    = grant_d;
          lat_addr_nxt = grant_d ? d_addr : if_addr;
          if (grant_d && d_we) begin
            state_nxt    = WR;
            ram_wa_nxt   = d_addr;
            ram_data_nxt = d_wdata;
            ram_wren_nxt = 1'b1;
          end else begin
            state_nxt  = RD;
            rd_cnt_nxt = '0;
            ram_ra_nxt = grant_d ? d_addr : if_addr;
          end
        end
      end

      WR: begin
        state_nxt  = DONE;
        d_ack_nxt  = win_d;
        if_ack_nxt = ~win_d;
      end

      RD: begin
        if (rd_cnt == RD_LAST) begin
          state_nxt  = DONE;
          cap_d      = win_d;
          cap_if     = ~win_d;
          d_ack_nxt  = win_d;
          if_ack_nxt = ~win_d;
        end else begin
          rd_cnt_nxt = rd_cnt + 3'd1;
          ram_ra_nxt = lat_addr;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // Registered RAM pins, acks and busy. The asynchronous reset clears
  // ram_wren at once, so a write in flight is never committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      ram_wren <= 1'b0;
      ram_ra   <= '0;
      ram_wa   <= '0;
      ram_data <= '0;
      busy     <= 1'b0;
    end else begin
      if_ack   <= if_ack_nxt;
      d_ack    <= d_ack_nxt;
      ram_wren <= ram_wren_nxt;
      ram_ra   <= ram_ra_nxt;
      ram_wa   <= ram_wa_nxt;
      ram_data <= ram_data_nxt;
      busy     <= busy_nxt;
    end
  end

  // Read-data registers. Each one holds its value until the next completed
  // read on its own port, so a write never disturbs d_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if (cap_if) begin
        if_rdata <= ram_q;
      end
      if (cap_d) begin
        d_rdata <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. The bench contains two instances:
//   dut   RD_LAT = 1, used for the main function, arbitration and reset abort
//   dut3  RD_LAT = 3, used for the long-latency fetch timing
// Each instance has a behavioural RAM with the matching read latency.
// Expected completions are pushed to a scoreboard queue when a request is
// driven. They are popped and compared when an ack appears.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;

  // Signals for the RD_LAT = 1 instance.
  logic        if_req, d_req, d_we;
  logic [7:0]  if_addr, d_addr;
  logic [31:0] d_wdata;
  logic        if_ack, d_ack, ram_wren, busy;
  logic [31:0] if_rdata, d_rdata, ram_data, ram_q;
  logic [7:0]  ram_ra, ram_wa;

  // Signals for the RD_LAT = 3 instance.
  logic        f3_req, d3_req, d3_we;
  logic [7:0]  f3_addr, d3_addr;
  logic [31:0] d3_wdata;
  logic        f3_ack, d3_ack, ram3_wren, busy3;
  logic [31:0] f3_rdata, d3_rdata, ram3_data, ram3_q;
  logic [7:0]  ram3_ra, ram3_wa;

  // RAM preload port, driven by the bench and shared by both RAMs.
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  int errors;
  int checks;

  typedef struct packed {
    logic        is_d;
    logic [31:0] d_exp;
    logic [31:0] if_exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_d;
  logic [31:0] model_if;

  mem_port_arbiter #(.AW(8), .DW(32), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_ra(ram_ra), .ram_wa(ram_wa), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q), .busy(busy)
  );

  mem_port_arbiter #(.AW(8), .DW(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(f3_req), .if_addr(f3_addr), .if_ack(f3_ack), .if_rdata(f3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
    .d_ack(d3_ack), .d_rdata(d3_rdata),
    .ram_ra(ram3_ra), .ram_wa(ram3_wa), .ram_data(ram3_data),
    .ram_wren(ram3_wren), .ram_q(ram3_q), .busy(busy3)
  );

  // Clock generation: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAMs. Each read pipeline has RD_LAT register stages behind
  // the edge that captures the read address.
  logic [31:0] mem  [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] q1;
  logic [31:0] p3 [0:2];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr]  <= pre_data;
      mem3[pre_addr] <= pre_data;
    end else begin
      if (ram_wren)  mem[ram_wa]   <= ram_data;
      if (ram3_wren) mem3[ram3_wa] <= ram3_data;
    end
    q1    <= mem[ram_ra];
    p3[0] <= mem3[ram3_ra];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign ram_q  = q1;
  assign ram3_q = p3[2];

  // Global time limit, so the run always ends on its own.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive the request inputs of the RD_LAT = 1 instance.
  task automatic applyStimulus(input logic fr, input logic [7:0] fa,
                               input logic dr, input logic dw,
                               input logic [7:0] da, input logic [31:0] dd);
    if_req  = fr;
    if_addr = fa;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  task automatic ram_load(input logic [7:0] a, input logic [31:0] v);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = v;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Wait, with a cycle bound, for an ack. Then pop the next scoreboard
  // entry and compare the winning port and both rdata registers.
  task automatic wait_ack(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!(if_ack || d_ack) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_ack_seen"}, {31'b0, (if_ack | d_ack)}, 32'd1);
    if ((if_ack || d_ack) && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checkOutput({tag, "_port"}, {31'b0, d_ack}, {31'b0, e.is_d});
      checkOutput({tag, "_single_ack"}, {31'b0, (if_ack & d_ack)}, 32'd0);
      checkOutput({tag, "_d_rdata"}, d_rdata, e.d_exp);
      checkOutput({tag, "_if_rdata"}, if_rdata, e.if_exp);
    end
  endtask

  task automatic push_exp(input logic is_d);
    exp_t e;
    e.is_d   = is_d;
    e.d_exp  = model_d;
    e.if_exp = model_if;
    sb_q.push_back(e);
  endtask

  initial begin
    logic exp_win [0:2];
    errors   = 0;
    checks   = 0;
    model_d  = 32'h0;
    model_if = 32'h0;
    rst_n    = 1'b0;
    pre_we   = 1'b0;
    pre_addr = 8'h0;
    pre_data = 32'h0;
    f3_req   = 1'b0;
    f3_addr  = 8'h0;
    d3_req   = 1'b0;
    d3_we    = 1'b0;
    d3_addr  = 8'h0;
    d3_wdata = 32'h0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);

`ifdef ARB_RR_EN
    exp_win[0] = 1'b1; exp_win[1] = 1'b0; exp_win[2] = 1'b1;
`else
    exp_win[0] = 1'b1; exp_win[1] = 1'b1; exp_win[2] = 1'b1;
`endif

    // Preload the RAMs while reset is held.
    @(negedge clk);
    ram_load(8'h10, 32'hDEADBEEF);
    ram_load(8'h30, 32'hA5A50030);
    ram_load(8'h40, 32'hC0DE0040);
    ram_load(8'h44, 32'h0BADF00D);
    ram_load(8'h50, 32'h50505050);
    ram_load(8'h60, 32'h11111111);

    // Reset state.
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_ram_wren", {31'b0, ram_wren}, 32'd0);
    checkOutput("rst_acks", {30'b0, if_ack, d_ack}, 32'd0);
    checkOutput("rst_ram_ra", {24'b0, ram_ra}, 32'd0);
    checkOutput("rst_ram_wa", {24'b0, ram_wa}, 32'd0);
    checkOutput("rst_ram_data", ram_data, 32'd0);
    checkOutput("rst_if_rdata", if_rdata, 32'd0);
    checkOutput("rst_d_rdata", d_rdata, 32'd0);
    checkOutput("rst_busy3", {31'b0, busy3}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", {31'b0, busy}, 32'd0);

    // Fetch from 0x10. ram_ra is held in cycles 1-2; the ack comes in cycle 3.
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0);
    model_if = 32'hDEADBEEF;
    push_exp(1'b0);
    @(negedge clk);
    checkOutput("f_c1_ram_ra", {24'b0, ram_ra}, 32'h10);
    checkOutput("f_c1_busy", {31'b0, busy}, 32'd1);
    checkOutput("f_c1_if_ack", {31'b0, if_ack}, 32'd0);
    @(negedge clk);
    checkOutput("f_c2_ram_ra", {24'b0, ram_ra}, 32'h10);
    checkOutput("f_c2_busy", {31'b0, busy}, 32'd1);
    checkOutput("f_c2_if_ack", {31'b0, if_ack}, 32'd0);
    @(negedge clk);
    checkOutput("f_c3_if_ack", {31'b0, if_ack}, 32'd1);
    checkOutput("f_c3_busy", {31'b0, busy}, 32'd1);
    checkOutput("f_c3_ram_ra", {24'b0, ram_ra}, 32'h0);
    wait_ack("fetch10");
    applyStimulus(1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("f_c4_busy", {31'b0, busy}, 32'd0);
    checkOutput("f_c4_if_ack", {31'b0, if_ack}, 32'd0);

    // Store 0x12345678 to 0x20. The write pulses in cycle 1; the ack comes
    // in cycle 2.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 32'h12345678);
    push_exp(1'b1);
    @(negedge clk);
    checkOutput("w_c1_wren", {31'b0, ram_wren}, 32'd1);
    checkOutput("w_c1_ram_wa", {24'b0, ram_wa}, 32'h20);
    checkOutput("w_c1_ram_data", ram_data, 32'h12345678);
    checkOutput("w_c1_ram_ra", {24'b0, ram_ra}, 32'h0);
    checkOutput("w_c1_d_ack", {31'b0, d_ack}, 32'd0);
    @(negedge clk);
    checkOutput("w_c2_wren", {31'b0, ram_wren}, 32'd0);
    checkOutput("w_c2_d_ack", {31'b0, d_ack}, 32'd1);
    wait_ack("store20");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("w_c3_busy", {31'b0, busy}, 32'd0);
    checkOutput("w_c3_d_ack", {31'b0, d_ack}, 32'd0);

    // Load back from 0x20. The new data is returned; if_rdata is unchanged.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 32'h0);
    model_d = 32'h12345678;
    push_exp(1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ld_c2_d_ack", {31'b0, d_ack}, 32'd0);
    @(negedge clk);
    checkOutput("ld_c3_d_ack", {31'b0, d_ack}, 32'd1);
    wait_ack("load20");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);

    // A load whose request drops in cycle 1 still completes exactly once.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h50, 32'h0);
    model_d = 32'h50505050;
    push_exp(1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h50, 32'h0);
    @(negedge clk);
    checkOutput("drop_c2_d_ack", {31'b0, d_ack}, 32'd0);
    @(negedge clk);
    checkOutput("drop_c3_d_ack", {31'b0, d_ack}, 32'd1);
    wait_ack("drop50");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("drop_after_busy", {31'b0, busy}, 32'd0);
      checkOutput("drop_after_ra", {24'b0, ram_ra}, 32'h0);
      checkOutput("drop_after_ack", {31'b0, d_ack}, 32'd0);
    end

    // Assert reset during WR. ram_wren and busy drop at once; the RAM keeps
    // its old value and no ack appears.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h60, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("abort_pre_wren", {31'b0, ram_wren}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_wren", {31'b0, ram_wren}, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_ram_wa", {24'b0, ram_wa}, 32'h0);
    checkOutput("abort_ram_data", ram_data, 32'h0);
    checkOutput("abort_d_rdata", d_rdata, 32'h0);
    checkOutput("abort_if_rdata", if_rdata, 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    model_d  = 32'h0;
    model_if = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_ack", {30'b0, if_ack, d_ack}, 32'd0);
    end
    checkOutput("abort_mem60", mem[8'h60], 32'h11111111);

    // Arbitration contests with both requests high. After each ack the
    // winner drops its request for the DONE cycle and re-raises it in IDLE.
    applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 8'h30, 32'h0);
    for (int k = 0; k < 3; k++) begin
      if (exp_win[k]) model_d = 32'hA5A50030;
      else            model_if = 32'hC0DE0040;
      push_exp(exp_win[k]);
      @(negedge clk);
      wait_ack($sformatf("arb%0d", k));
      if (d_ack) d_req = 1'b0;
      if (if_ack) if_req = 1'b0;
      @(negedge clk);
      checkOutput("arb_ack_pulse", {30'b0, if_ack, d_ack}, 32'd0);
      if (k < 2) begin
        if_req = 1'b1;
        d_req  = 1'b1;
      end
    end

    // With d_req now low, fetch is granted in this IDLE cycle and reads
    // from the next cycle on.
    checkOutput("arb_idle_busy", {31'b0, busy}, 32'd0);
    model_if = 32'hC0DE0040;
    push_exp(1'b0);
    @(negedge clk);
    checkOutput("arb_fetch_ra", {24'b0, ram_ra}, 32'h40);
    checkOutput("arb_fetch_busy", {31'b0, busy}, 32'd1);
    wait_ack("arb_fetch");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("sb_drained", sb_q.size(), 32'd0);

    // RD_LAT = 3: ram_ra is stable in cycles 1-4; the ack comes in cycle 5.
    f3_req  = 1'b1;
    f3_addr = 8'h44;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("lat3_c%0d_ra", c), {24'b0, ram3_ra}, 32'h44);
      checkOutput($sformatf("lat3_c%0d_ack", c), {31'b0, f3_ack}, 32'd0);
    end
    @(negedge clk);
    checkOutput("lat3_c5_ack", {31'b0, f3_ack}, 32'd1);
    checkOutput("lat3_c5_rdata", f3_rdata, 32'h0BADF00D);
    checkOutput("lat3_c5_ra", {24'b0, ram3_ra}, 32'h0);
    f3_req = 1'b0;
    @(negedge clk);
    checkOutput("lat3_c6_ack", {31'b0, f3_ack}, 32'd0);
    checkOutput("lat3_c6_busy", {31'b0, busy3}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
